// File: rtl/astar_open_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : astar_open_queue_if
// Description : Command/response bundle between the A* path controller and
//               the open-list store (astar_open_queue).
//   cmd_valid/cmd_ready : command handshake (accepted when both high)
//   cmd_op              : 0 NOP, 1 PUSH, 2 POP, 3 CLEAR
//   cmd_x/y, cmd_g/f    : PUSH record
//   rsp_valid           : one-cycle response pulse
//   rsp_status          : 0 INSERTED .. 6 CLEARED
//   rsp_x/y, rsp_g/f    : returned / echoed record
//   count, empty, full  : occupancy
// Revision    : 1.0 - initial release
// ============================================================================
interface astar_open_queue_if #(
    parameter int COORD_W = 8,
    parameter int COST_W  = 16,
    parameter int DEPTH   = 400,
    parameter int CNT_W   = $clog2(DEPTH + 1)
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;
    logic [COST_W-1:0]  cmd_g;
    logic [COST_W-1:0]  cmd_f;
    logic               rsp_valid;
    logic [2:0]         rsp_status;
    logic [COORD_W-1:0] rsp_x;
    logic [COORD_W-1:0] rsp_y;
    logic [COST_W-1:0]  rsp_g;
    logic [COST_W-1:0]  rsp_f;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               full;

    // Path controller side
    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_g, cmd_f,
        input  cmd_ready, rsp_valid, rsp_status, rsp_x, rsp_y, rsp_g, rsp_f,
               count, empty, full
    );

    // Open-list store side
    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_g, cmd_f,
        output cmd_ready, rsp_valid, rsp_status, rsp_x, rsp_y, rsp_g, rsp_f,
               count, empty, full
    );
endinterface
`default_nettype wire

// File: rtl/astar_open_queue.sv
`default_nettype none
// ============================================================================
// Module      : astar_open_queue
// Description : Open-list store for the A* path engine. Holds (x, y, g, f)
//               records and serves PUSH (insert or improve), POP (remove the
//               minimum-f record, ties to lowest index) and CLEAR. The store
//               is scanned one entry per cycle through a single read port;
//               the final DONE cycle performs the one storage write.
// Ports       : sync  - clock, rising edge
//               reset - asynchronous, active-low reset
//               q     - astar_open_queue_if.slave command/response bundle
// Revision    : 1.0 - initial release
// ============================================================================
module astar_open_queue #(
    parameter int COORD_W = 8,
    parameter int COST_W  = 16,
    parameter int DEPTH   = 400,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  wire logic          sync,
    input  wire logic          reset,
    astar_open_queue_if.slave  q
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] c_OP_PUSH  = 2'd1;
    localparam logic [1:0] c_OP_POP   = 2'd2;
    localparam logic [1:0] c_OP_CLEAR = 2'd3;

    localparam logic [2:0] c_ST_INSERTED   = 3'd0;
    localparam logic [2:0] c_ST_UPDATED    = 3'd1;
    localparam logic [2:0] c_ST_NOT_BETTER = 3'd2;
    localparam logic [2:0] c_ST_FULL       = 3'd3;
    localparam logic [2:0] c_ST_POPPED     = 3'd4;
    localparam logic [2:0] c_ST_EMPTY      = 3'd5;
    localparam logic [2:0] c_ST_CLEARED    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    // Storage (not reset: entries at or above count are don't-care)
    logic [COORD_W-1:0] r_mem_x [DEPTH];
    logic [COORD_W-1:0] r_mem_y [DEPTH];
    logic [COST_W-1:0]  r_mem_g [DEPTH];
    logic [COST_W-1:0]  r_mem_f [DEPTH];

    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_op;
    logic [COORD_W-1:0] r_cx, r_cy;
    logic [COST_W-1:0]  r_cg, r_cf;
    logic [IDX_W-1:0]   r_idx;

    // PUSH scan result
    logic               r_hit;
    logic [IDX_W-1:0]   r_hit_idx;
    logic [COST_W-1:0]  r_hit_f;

    // POP scan result: running minimum plus a copy of the last entry,
    // which is moved into the vacated slot
    logic [IDX_W-1:0]   r_min_idx;
    logic [COORD_W-1:0] r_min_x, r_min_y;
    logic [COST_W-1:0]  r_min_g, r_min_f;
    logic [COORD_W-1:0] r_last_x, r_last_y;
    logic [COST_W-1:0]  r_last_g, r_last_f;

    logic               r_rsp_valid;
    logic [2:0]         r_rsp_status;
    logic [COORD_W-1:0] r_rsp_x, r_rsp_y;
    logic [COST_W-1:0]  r_rsp_g, r_rsp_f;

    logic               w_accept;
    logic               w_full;
    logic [IDX_W-1:0]   w_last_idx;
    logic               w_at_last;
    logic [COORD_W-1:0] w_rd_x, w_rd_y;
    logic [COST_W-1:0]  w_rd_g, w_rd_f;
    logic               w_we;
    logic [IDX_W-1:0]   w_wa;
    logic [COORD_W-1:0] w_wx, w_wy;
    logic [COST_W-1:0]  w_wg, w_wf;

    assign w_accept   = q.cmd_valid && (r_state == ST_IDLE);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    // Only meaningful while count>0 (SCAN and non-empty DONE)
    assign w_last_idx = IDX_W'(r_count - CNT_W'(1));
    assign w_at_last  = (r_idx == w_last_idx);

    // Single read port addressed by the scan index
    assign w_rd_x = r_mem_x[r_idx];
    assign w_rd_y = r_mem_y[r_idx];
    assign w_rd_g = r_mem_g[r_idx];
    assign w_rd_f = r_mem_f[r_idx];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge sync or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (q.cmd_op == c_OP_CLEAR) begin
                        w_state_nxt = ST_DONE;
                    end else if (q.cmd_op != 2'd0) begin
                        w_state_nxt = (r_count == '0) ? ST_DONE : ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (w_at_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage write decode (only in DONE)
    // ------------------------------------------------------------------
    always_comb begin
        w_we = 1'b0;
        w_wa = '0;
        w_wx = r_cx;
        w_wy = r_cy;
        w_wg = r_cg;
        w_wf = r_cf;
        if (r_state == ST_DONE) begin
            if (r_op == c_OP_PUSH) begin
                if (r_hit) begin
                    if (r_cf < r_hit_f) begin
                        w_we = 1'b1;
                        w_wa = r_hit_idx;
                    end
                end else if (!w_full) begin
                    w_we = 1'b1;
                    w_wa = IDX_W'(r_count);
                end
            end else if (r_op == c_OP_POP) begin
                // Back-fill the hole with the last entry unless the hole is last
                if ((r_count != '0) && (r_min_idx != w_last_idx)) begin
                    w_we = 1'b1;
                    w_wa = r_min_idx;
                    w_wx = r_last_x;
                    w_wy = r_last_y;
                    w_wg = r_last_g;
                    w_wf = r_last_f;
                end
            end
        end
    end

    always_ff @(posedge sync) begin
        if (w_we) begin
            r_mem_x[w_wa] <= w_wx;
            r_mem_y[w_wa] <= w_wy;
            r_mem_g[w_wa] <= w_wg;
            r_mem_f[w_wa] <= w_wf;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: command capture, scan, response
    // ------------------------------------------------------------------
    always_ff @(posedge sync or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_op         <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_cg         <= '0;
            r_cf         <= '0;
            r_idx        <= '0;
            r_hit        <= 1'b0;
            r_hit_idx    <= '0;
            r_hit_f      <= '0;
            r_min_idx    <= '0;
            r_min_x      <= '0;
            r_min_y      <= '0;
            r_min_g      <= '0;
            r_min_f      <= '0;
            r_last_x     <= '0;
            r_last_y     <= '0;
            r_last_g     <= '0;
            r_last_f     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= '0;
            r_rsp_x      <= '0;
            r_rsp_y      <= '0;
            r_rsp_g      <= '0;
            r_rsp_f      <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= q.cmd_op;
                        r_cx  <= q.cmd_x;
                        r_cy  <= q.cmd_y;
                        r_cg  <= q.cmd_g;
                        r_cf  <= q.cmd_f;
                        r_idx <= '0;
                        r_hit <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_op == c_OP_PUSH) begin
                        if (!r_hit && (w_rd_x == r_cx) && (w_rd_y == r_cy)) begin
                            r_hit     <= 1'b1;
                            r_hit_idx <= r_idx;
                            r_hit_f   <= w_rd_f;
                        end
                    end else begin
                        // Strict less-than keeps the lowest index on ties
                        if ((r_idx == '0) || (w_rd_f < r_min_f)) begin
                            r_min_idx <= r_idx;
                            r_min_x   <= w_rd_x;
                            r_min_y   <= w_rd_y;
                            r_min_g   <= w_rd_g;
                            r_min_f   <= w_rd_f;
                        end
                    end
                    if (w_at_last) begin
                        r_last_x <= w_rd_x;
                        r_last_y <= w_rd_y;
                        r_last_g <= w_rd_g;
                        r_last_f <= w_rd_f;
                    end
                end
                ST_DONE: begin
                    r_rsp_valid <= 1'b1;
                    if (r_op == c_OP_PUSH) begin
                        r_rsp_x <= r_cx;
                        r_rsp_y <= r_cy;
                        r_rsp_g <= r_cg;
                        r_rsp_f <= r_cf;
                        if (r_hit) begin
                            r_rsp_status <= (r_cf < r_hit_f) ? c_ST_UPDATED
                                                             : c_ST_NOT_BETTER;
                        end else if (!w_full) begin
                            r_rsp_status <= c_ST_INSERTED;
                            r_count      <= r_count + CNT_W'(1);
                        end else begin
                            r_rsp_status <= c_ST_FULL;
                        end
                    end else if (r_op == c_OP_POP) begin
                        if (r_count == '0) begin
                            r_rsp_status <= c_ST_EMPTY;
                            r_rsp_x      <= '0;
                            r_rsp_y      <= '0;
                            r_rsp_g      <= '0;
                            r_rsp_f      <= '0;
                        end else begin
                            r_rsp_status <= c_ST_POPPED;
                            r_rsp_x      <= r_min_x;
                            r_rsp_y      <= r_min_y;
                            r_rsp_g      <= r_min_g;
                            r_rsp_f      <= r_min_f;
                            r_count      <= r_count - CNT_W'(1);
                        end
                    end else begin
                        r_rsp_status <= c_ST_CLEARED;
                        r_rsp_x      <= '0;
                        r_rsp_y      <= '0;
                        r_rsp_g      <= '0;
                        r_rsp_f      <= '0;
                        r_count      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q.cmd_ready  = (r_state == ST_IDLE);
    assign q.rsp_valid  = r_rsp_valid;
    assign q.rsp_status = r_rsp_status;
    assign q.rsp_x      = r_rsp_x;
    assign q.rsp_y      = r_rsp_y;
    assign q.rsp_g      = r_rsp_g;
    assign q.rsp_f      = r_rsp_f;
    assign q.count      = r_count;
    assign q.empty      = (r_count == '0);
    assign q.full       = w_full;
endmodule
`default_nettype wire

// File: doc/astar_open_queue.md
Name: astar_open_queue

Overview:
- Parametrised open-list store for the A* path engine; replaces the fixed 400-entry shift-based open list.
- Holds (x, y, g, f) node records. Serves three commands over a valid/ready handshake: PUSH (insert, or improve an existing node), POP (remove the minimum-f node) and CLEAR.
- Uses one storage port and scans sequentially, one entry per cycle. The path controller sits upstream and issues the commands.

Parameters:
- COORD_W, 8, width of the x and y coordinates.
- COST_W, 16, width of g and f costs (unsigned).
- DEPTH, 400, maximum number of entries; legal range 2 or more.
- CNT_W, $clog2(DEPTH+1), width of the count output.

Ports:
- sync  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both high.
- cmd_op  in  2  0 NOP, 1 PUSH, 2 POP, 3 CLEAR.
- cmd_x, cmd_y  in  COORD_W  PUSH coordinates.
- cmd_g, cmd_f  in  COST_W  PUSH costs.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  3  0 INSERTED, 1 UPDATED, 2 NOT_BETTER, 3 FULL, 4 POPPED, 5 EMPTY, 6 CLEARED.
- rsp_x, rsp_y  out  COORD_W  node record returned by POP.
- rsp_g, rsp_f  out  COST_W  costs returned by POP.
- count  out  CNT_W  number of valid entries.
- empty, full  out  1  high when count==0 / count==DEPTH.

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE, count=0, rsp_valid=0, rsp_* = 0, cmd_ready=1 once reset releases.
  - Storage contents are not cleared; entries at or above count are don't-care.
- Command capture:
  - cmd_* fields are latched on the accepting edge; later changes to the inputs have no effect.
  - NOP is accepted with no response.
- States:
  - IDLE -> SCAN on an accepted PUSH/POP when count>0.
  - IDLE -> DONE on an accepted PUSH/POP when count==0, or on CLEAR.
  - SCAN examines entry i (i = 0..count-1), one per edge. The edge that examines entry count-1 moves to DONE.
  - DONE: one edge performs the storage write and count update, loads rsp_*, sets rsp_valid=1, and returns to IDLE.
- Latency:
  - rsp_valid is high in the cycle following edge N+1 after the accepting edge, where N = count at acceptance (N=0 for CLEAR).
  - cmd_ready is low from the accepting edge until that same edge.
  - No backpressure on the response; rsp_valid and cmd_ready may be high together.
- PUSH:
  - Match is on x and y equal.
  - Match found and cmd_f < stored f (strict, unsigned): overwrite g and f, status UPDATED. This applies even when full.
  - Match found and cmd_f >= stored f: storage unchanged, status NOT_BETTER.
  - No match and count<DEPTH: write the record at index count, count+1, status INSERTED.
  - No match and count==DEPTH: storage unchanged, status FULL.
  - rsp_x/y/g/f echo the command fields.
- POP:
  - Returns the entry with minimum f; ties go to the lowest index.
  - The vacated slot is filled by moving entry count-1 into it (no move when it is the last entry). count-1, status POPPED.
  - POP on empty: status EMPTY, rsp_x/y/g/f = 0, count unchanged.
- CLEAR: count=0, status CLEARED.
- Arithmetic: all comparisons are unsigned at COST_W; no saturation or wrap logic is needed because costs are never summed here.
- Reset mid-SCAN/DONE: the operation is abandoned, no response is issued and count=0. The next command behaves as on an empty queue.

Test Plan:
- Empty POP: release reset, then POP -> rsp_valid after 1 edge, status EMPTY (5), count 0, empty=1.
- Ordering:
  - PUSH (3,4,g2,f10), (5,5,g1,f7), (1,1,g0,f7) -> each INSERTED, count 3.
  - Three POPs -> (5,5,f7), then (1,1,f7), then (3,4,f10).
  - count ends at 0.
- Update:
  - PUSH (3,4,g2,f10) -> INSERTED.
  - PUSH (3,4,g1,f8) -> UPDATED.
  - PUSH (3,4,g0,f8) -> NOT_BETTER.
  - POP -> (3,4,g1,f8).
- Full, with DEPTH=4:
  - Four distinct PUSHes -> full=1.
  - Fifth distinct PUSH -> FULL, count 4.
  - PUSH of an existing node with lower f -> UPDATED, count 4.
- Latency/handshake:
  - With count=3, POP accepted -> cmd_ready low for 4 edges, rsp_valid a single cycle after edge 4.
  - cmd_valid held high throughout -> the next command is accepted only once cmd_ready returns high.
- Reset mid-op:
  - With count=5, POP accepted; drive reset low 2 edges later -> rsp_valid stays 0, count 0, cmd_ready 1 after release.
  - Next POP -> EMPTY.
  - CLEAR on a non-empty queue -> CLEARED after 1 edge, count 0.
